// File: rtl/rom_loader.sv
// Boot-time ROM loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive ROM addresses while holding the core in reset.
module rom_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LEN_W     = 16,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wen,
  output logic [31:0]      w_addr,
  output logic [31:0]      w_data,
  output logic             busy,
  output logic             core_hold,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [23:0]      word_q, word_d;
  logic [31:0]      w_addr_q, w_addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic             err_q, err_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    idle_cnt_d = idle_cnt_q;
    word_d     = word_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (load_len != '0) begin
            len_d      = load_len;
            word_cnt_d = '0;
            byte_idx_d = 2'd0;
            addr_d     = BASE_ADDR;
            idle_cnt_d = '0;
            state_d    = RECV;
          end else begin
            state_d = DONE;
          end
        end
      end
      RECV: begin
        if (byte_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          idle_cnt_d = '0;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              // The fourth byte goes straight into the write register so
              // the write port is valid in the very next cycle.
              w_addr_d = addr_q;
              w_data_d = {byte_data, word_q};
              state_d  = WRITE;
            end
          endcase
        end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        addr_d     = addr_q + 32'd4;
        word_cnt_d = word_cnt_q + LEN_W'(1);
        byte_idx_d = 2'd0;
        idle_cnt_d = '0;
        state_d    = ((word_cnt_q + LEN_W'(1)) == len_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= 2'd0;
      addr_q     <= '0;
      idle_cnt_q <= '0;
      word_q     <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      idle_cnt_q <= idle_cnt_d;
      word_q     <= word_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      err_q      <= err_d;
    end
  end

  assign byte_ready = (state_q == RECV);
  assign wen        = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign core_hold  = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomised directed bench for rom_loader; expected writes come from a
// byte-list model of the load (word i at BASE+4i, bytes packed little-endian).
module tb_rom_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load_start;
  logic [15:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, wen, busy, core_hold, done, err;
  logic [31:0] w_addr, w_data;

  rom_loader #(.BASE_ADDR(BASE), .LEN_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wen(wen), .w_addr(w_addr), .w_data(w_data), .busy(busy),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Monitor: observes the DUT on the falling edge.
  int cyc = 0, hs_cnt = 0, done_cnt = 0, err_cnt = 0, overlap = 0;
  int last_hs_cyc = 0, err_cyc = 0, wen_cyc = 0, done_cyc = 0, start_cyc = 0;
  logic [63:0] wq[$];

  always @(negedge clk) begin
    cyc++;
    if (byte_valid && byte_ready) begin hs_cnt++; last_hs_cyc = cyc; end
    if (wen) begin wq.push_back({w_addr, w_data}); wen_cyc = cyc; end
    if (wen && byte_ready) overlap++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (load_start && !busy && rstn) start_cyc = cyc;
  end

  logic [7:0] tx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int i);
    logic [31:0] w = 0;
    for (int k = 0; k < 4; k++) w = w + (32'(tx_q[4*i+k]) << (8*k));
    return w;
  endfunction

  task automatic make_bytes(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
  endtask

  task automatic start(input int len);
    load_start = 1'b1;
    load_len   = 16'(len);
    @(posedge clk); #1;
    load_start = 1'b0;
    load_len   = 16'($urandom);
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random gaps
  task automatic feed(input int lo, input int hi, input int gap_mode);
    for (int i = lo; i < hi; i++) begin
      int g;
      int b;
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
      repeat (g) begin
        byte_valid = 1'b0; byte_data = 8'($urandom);
        @(posedge clk); #1;
      end
      byte_valid = 1'b1; byte_data = tx_q[i];
      b = 0;
      forever begin
        @(negedge clk);
        if (byte_ready) break;
        b++;
        if (b > 20) begin
          chk("byte_ready_timeout", 64'(b), 64'(0));
          byte_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int b = 0;
    while (done_cnt == d0 && b < 30) begin @(negedge clk); b++; end
    chk("done_pulse_count", 64'(done_cnt - d0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    chk({tag, "_wen_count"}, 64'(wq.size() - base), 64'(n));
    for (int i = 0; i < n && base + i < wq.size(); i++)
      chk({tag, "_write"}, wq[base+i], {BASE + 32'(4*i), model_word(i)});
  endtask

  task automatic run_load(input string tag, input int len, input int gap_mode);
    int w0, h0, d0, o0;
    make_bytes(4*len);
    w0 = wq.size(); h0 = hs_cnt; d0 = done_cnt; o0 = overlap;
    start(len);
    feed(0, 4*len, gap_mode);
    wait_done(d0);
    check_writes(tag, w0, len);
    chk({tag, "_handshakes"}, 64'(hs_cnt - h0), 64'(4*len));
    chk({tag, "_ready_in_write"}, 64'(overlap - o0), 64'(0));
    chk({tag, "_idle_after"}, {62'd0, busy, core_hold}, 64'(0));
  endtask

  initial begin
    int w0, h0, d0, e0;
    int b;
    rstn = 1'b0; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {58'd0, byte_ready, wen, busy, core_hold, done, err}, 64'(0));
    chk("reset_waddr_wdata", {w_addr, w_data}, 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single word with fixed bytes
    tx_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    w0 = wq.size(); d0 = done_cnt;
    start(1);
    @(negedge clk);
    chk("single_busy_hold", {62'd0, busy, core_hold}, 64'd3);
    @(posedge clk); #1;
    feed(0, 4, 0);
    wait_done(d0);
    chk("single_write", wq[w0], {32'h0, 32'h1234_5678});
    chk("single_wen_count", 64'(wq.size() - w0), 64'(1));
    chk("single_done_after_wen", 64'(done_cyc - wen_cyc), 64'(1));
    chk("single_idle_after", {62'd0, busy, core_hold}, 64'(0));

    // Three words, byte_valid toggling
    run_load("three_toggle", 3, 1);

    // Random lengths and gap patterns
    for (int t = 0; t < 6; t++)
      run_load("random_load", int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));

    // Zero length with a byte on offer that must not be consumed
    w0 = wq.size(); h0 = hs_cnt; d0 = done_cnt;
    byte_valid = 1'b1; byte_data = 8'hA5;
    start(0);
    repeat (4) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("zero_done_count", 64'(done_cnt - d0), 64'(1));
    chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'(1));
    chk("zero_no_wen", 64'(wq.size() - w0), 64'(0));
    chk("zero_no_handshake", 64'(hs_cnt - h0), 64'(0));

    // Timeout after 5 bytes of a 2-word load
    make_bytes(8);
    w0 = wq.size(); d0 = done_cnt; e0 = err_cnt;
    start(2);
    feed(0, 5, 0);
    b = 0;
    while (err_cnt == e0 && b < 60) begin @(negedge clk); b++; end
    chk("timeout_err_count", 64'(err_cnt - e0), 64'(1));
    chk("timeout_err_latency", 64'(err_cyc - last_hs_cyc), 64'(TMO + 1));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    check_writes("timeout", w0, 1);
    chk("timeout_no_done", 64'(done_cnt - d0), 64'(0));
    chk("timeout_idle", {62'd0, busy, err}, 64'(0));

    // Reset asserted after the 2nd byte of word 1
    make_bytes(8);
    w0 = wq.size();
    start(2);
    feed(0, 6, 0);
    rstn = 1'b0;
    #1;
    chk("midreset_outputs", {58'd0, byte_ready, wen, busy, core_hold, done, err}, 64'(0));
    chk("midreset_waddr_wdata", {w_addr, w_data}, 64'(0));
    @(posedge clk); #1;
    chk("midreset_one_write", 64'(wq.size() - w0), 64'(1));
    rstn = 1'b1;
    @(posedge clk); #1;
    run_load("after_reset", 1, 2);

    // load_start while busy is ignored
    make_bytes(8);
    w0 = wq.size(); d0 = done_cnt;
    start(2);
    feed(0, 3, 0);
    start(5);
    feed(3, 8, 2);
    wait_done(d0);
    repeat (20) @(posedge clk);
    #1;
    check_writes("ignored_start", w0, 2);
    chk("ignored_start_done_once", 64'(done_cnt - d0), 64'(1));
    chk("ignored_start_idle", {62'd0, busy, core_hold}, 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
